// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller.
// Widths here are defaults; the top module re-exposes them as parameters.
package dds_pkg;

    localparam int unsigned WAVE_W       = 4;
    localparam int unsigned DEF_FREQ_W   = 32;
    localparam int unsigned DEF_DWELL_W  = 24;
    localparam int unsigned DEF_STEP_W   = 8;

    localparam logic [WAVE_W-1:0] WAVE_OFF    = 4'b0000;
    localparam logic [WAVE_W-1:0] WAVE_SINE   = 4'b0001;
    localparam logic [WAVE_W-1:0] WAVE_SQUARE = 4'b0010;
    localparam logic [WAVE_W-1:0] WAVE_TRI    = 4'b0100;
    localparam logic [WAVE_W-1:0] WAVE_SAW    = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/dds_next_wave.sv
// Picks the next enabled one-hot wave strictly above `cur` in `mask`.
// With cur = 0 it returns the lowest enabled wave.
module dds_next_wave
    import dds_pkg::*;
(
    input  logic [WAVE_W-1:0] mask,
    input  logic [WAVE_W-1:0] cur,
    output logic [WAVE_W-1:0] nxt,
    output logic              none
);

    logic seen;

    // Scan upward; bits become eligible once we are past the current wave
    always_comb begin
        nxt  = WAVE_OFF;
        none = 1'b1;
        seen = (cur == WAVE_OFF);
        for (int i = 0; i < int'(WAVE_W); i++) begin
            if (seen && mask[i] && none) begin
                nxt[i] = 1'b1;
                none   = 1'b0;
            end
            if (cur[i]) begin
                seen = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Sweep sequencer driving wave_select / freq_word of the dds core.
// Define DDS_SWEEP_LOOP_EN to make the sweep wrap forever instead of finishing.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned FREQ_W  = DEF_FREQ_W,
    parameter int unsigned DWELL_W = DEF_DWELL_W,
    parameter int unsigned STEP_W  = DEF_STEP_W
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WAVE_W-1:0]  mode_en,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [STEP_W-1:0]  n_steps,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WAVE_W-1:0]  wave_select,
    output logic [FREQ_W-1:0]  freq_word,
    output logic               phase_clr,
    output logic               busy,
    output logic               done
);

    sweep_state_t state_q, state_d;

    logic [WAVE_W-1:0]  wave_q, wave_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               pclr_q, pclr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WAVE_W-1:0]  mask_q, mask_d;
    logic [FREQ_W-1:0]  fstart_q, fstart_d;
    logic [FREQ_W-1:0]  fstep_q, fstep_d;
    logic [STEP_W-1:0]  nsteps_q, nsteps_d;
    logic [DWELL_W-1:0] dwell_m1_q, dwell_m1_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_idx_q, step_idx_d;

    logic [WAVE_W-1:0]  first_mask;
    logic [WAVE_W-1:0]  first_wave, next_wave;
    logic               first_none, next_none;
    logic [DWELL_W-1:0] dwell_m1_in;

    // In IDLE the live mask is used so the first wave is known on the start cycle
    assign first_mask  = (state_q == IDLE) ? mode_en : mask_q;
    assign dwell_m1_in = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    dds_next_wave u_first (
        .mask (first_mask),
        .cur  (WAVE_OFF),
        .nxt  (first_wave),
        .none (first_none)
    );

    dds_next_wave u_next (
        .mask (mask_q),
        .cur  (wave_q),
        .nxt  (next_wave),
        .none (next_none)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            wave_q     <= WAVE_OFF;
            freq_q     <= '0;
            pclr_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mask_q     <= WAVE_OFF;
            fstart_q   <= '0;
            fstep_q    <= '0;
            nsteps_q   <= '0;
            dwell_m1_q <= '0;
            cnt_q      <= '0;
            step_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            wave_q     <= wave_d;
            freq_q     <= freq_d;
            pclr_q     <= pclr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mask_q     <= mask_d;
            fstart_q   <= fstart_d;
            fstep_q    <= fstep_d;
            nsteps_q   <= nsteps_d;
            dwell_m1_q <= dwell_m1_d;
            cnt_q      <= cnt_d;
            step_idx_q <= step_idx_d;
        end
    end

    // Next-state and registered-output logic; STEP is the first cycle of its point
    always_comb begin
        state_d    = state_q;
        wave_d     = wave_q;
        freq_d     = freq_q;
        pclr_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mask_d     = mask_q;
        fstart_d   = fstart_q;
        fstep_d    = fstep_q;
        nsteps_d   = nsteps_q;
        dwell_m1_d = dwell_m1_q;
        cnt_d      = cnt_q;
        step_idx_d = step_idx_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mask_d     = mode_en;
                    fstart_d   = f_start;
                    fstep_d    = f_step;
                    nsteps_d   = n_steps;
                    dwell_m1_d = dwell_m1_in;
                    if (first_none) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = DWELL;
                        wave_d     = first_wave;
                        freq_d     = f_start;
                        step_idx_d = '0;
                        cnt_d      = dwell_m1_in;
                        pclr_d     = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            DWELL, STEP: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - DWELL_W'(1);
                    state_d = DWELL;
                end else if (step_idx_q < nsteps_q) begin
                    state_d    = STEP;
                    freq_d     = freq_q + fstep_q;
                    step_idx_d = step_idx_q + STEP_W'(1);
                    cnt_d      = dwell_m1_q;
                end else if (!next_none) begin
                    state_d    = DWELL;
                    wave_d     = next_wave;
                    freq_d     = fstart_q;
                    step_idx_d = '0;
                    cnt_d      = dwell_m1_q;
                    pclr_d     = 1'b1;
                end else begin
`ifdef DDS_SWEEP_LOOP_EN
                    state_d    = DWELL;
                    wave_d     = first_wave;
                    freq_d     = fstart_q;
                    step_idx_d = '0;
                    cnt_d      = dwell_m1_q;
                    pclr_d     = 1'b1;
`else
                    state_d = DONE;
                    wave_d  = WAVE_OFF;
                    freq_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE
        if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
            wave_d  = WAVE_OFF;
            freq_d  = '0;
            busy_d  = 1'b0;
            pclr_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign wave_select = wave_q;
    assign freq_word   = freq_q;
    assign phase_clr   = pclr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: a table of whole sweeps plus hand sequences.
// Loop-mode checks run when DDS_SWEEP_LOOP_EN is defined.
module tb_dds_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start, stop;
    logic [3:0]  mode_en;
    logic [31:0] f_start, f_step;
    logic [7:0]  n_steps;
    logic [23:0] dwell;
    logic [3:0]  wave_select;
    logic [31:0] freq_word;
    logic        phase_clr, busy, done;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]  mode;
        logic [31:0] fs;
        logic [31:0] fst;
        logic [7:0]  n;
        logic [23:0] d;
        int          exp_lat;
        int          exp_pclr;
        int          exp_busy;
        logic [31:0] exp_freq;
        logic [3:0]  exp_wave;
    } vec_t;

    vec_t vecs[6];

    always #5 sys_clk = ~sys_clk;

    dds_sweep_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .stop        (stop),
        .mode_en     (mode_en),
        .f_start     (f_start),
        .f_step      (f_step),
        .n_steps     (n_steps),
        .dwell       (dwell),
        .wave_select (wave_select),
        .freq_word   (freq_word),
        .phase_clr   (phase_clr),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outs(input string name);
        chk({name, ".wave"}, 64'(wave_select), 64'h0);
        chk({name, ".freq"}, 64'(freq_word), 64'h0);
        chk({name, ".busy"}, 64'(busy), 64'h0);
        chk({name, ".pclr"}, 64'(phase_clr), 64'h0);
        chk({name, ".done"}, 64'(done), 64'h0);
    endtask

    // Issue a start pulse; returns at the negedge of cycle T+1
    task automatic pulse_start(input vec_t v);
        mode_en = v.mode;
        f_start = v.fs;
        f_step  = v.fst;
        n_steps = v.n;
        dwell   = v.d;
        start   = 1'b1;
        @(negedge sys_clk);
        start   = 1'b0;
    endtask

    initial begin
        int          lat, pcnt, bcnt;
        logic [31:0] lf;
        logic [3:0]  lw;
        logic        saw_done, bad;
        vec_t        v;

        vecs[0] = '{4'b0001, 32'd100, 32'd10, 8'd2, 24'd3, 10, 1, 9, 32'd120, 4'b0001};
        vecs[1] = '{4'b1010, 32'd5, 32'd1, 8'd0, 24'd2, 5, 2, 4, 32'd5, 4'b1000};
        vecs[2] = '{4'b0100, 32'hFFFF_FFF0, 32'h20, 8'd1, 24'd1, 3, 1, 2, 32'h10, 4'b0100};
        vecs[3] = '{4'b0011, 32'd7, 32'd3, 8'd2, 24'd0, 7, 2, 6, 32'd13, 4'b0010};
        vecs[4] = '{4'b0000, 32'd1, 32'd1, 8'd3, 24'd3, 1, 0, 0, 32'd0, 4'b0000};
        vecs[5] = '{4'b1111, 32'd0, 32'h100, 8'd1, 24'd2, 17, 4, 16, 32'h100, 4'b1000};

        sys_rst = 1'b1;
        start = 1'b0; stop = 1'b0;
        mode_en = '0; f_start = '0; f_step = '0; n_steps = '0; dwell = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_idle_outs("reset");

`ifndef DDS_SWEEP_LOOP_EN
        // Whole-sweep table: latency to done, phase_clr count, busy cycles, last point
        for (int t = 0; t < 6; t++) begin
            pulse_start(vecs[t]);
            lat = -1; pcnt = 0; bcnt = 0; lf = '0; lw = '0;
            for (int k = 1; k <= 200; k++) begin
                if (done) begin
                    lat = k;
                    chk($sformatf("v%0d.end_wave", t), 64'(wave_select), 64'h0);
                    chk($sformatf("v%0d.end_freq", t), 64'(freq_word), 64'h0);
                    chk($sformatf("v%0d.end_busy", t), 64'(busy), 64'h0);
                    break;
                end
                if (phase_clr) pcnt++;
                if (busy) bcnt++;
                if (wave_select != 4'b0) begin
                    lf = freq_word;
                    lw = wave_select;
                end
                @(negedge sys_clk);
            end
            chk($sformatf("v%0d.latency", t), 64'(lat), 64'(vecs[t].exp_lat));
            chk($sformatf("v%0d.pclr_cnt", t), 64'(pcnt), 64'(vecs[t].exp_pclr));
            chk($sformatf("v%0d.busy_cnt", t), 64'(bcnt), 64'(vecs[t].exp_busy));
            chk($sformatf("v%0d.last_freq", t), 64'(lf), 64'(vecs[t].exp_freq));
            chk($sformatf("v%0d.last_wave", t), 64'(lw), 64'(vecs[t].exp_wave));
            repeat (2) @(negedge sys_clk);
        end

        // Per-cycle trace with inputs disturbed and a start retried mid-sweep
        pulse_start(vecs[0]);
        bad = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (freq_word !== 32'(100 + 10 * ((k - 1) / 3)) || wave_select !== 4'b0001
                || busy !== 1'b1 || done !== 1'b0 || phase_clr !== (k == 1)) begin
                bad = 1'b1;
                $display("FAIL trace k=%0d: freq=%0d wave=%b busy=%b pclr=%b", k, freq_word,
                         wave_select, busy, phase_clr);
            end
            if (k == 2) begin f_start = 32'd999; f_step = 32'd1; mode_en = 4'b1111; end
            if (k == 5) start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
        end
        chk("trace.points", 64'(bad), 64'h0);
        chk("trace.done_at_10", 64'(done), 64'h1);
        repeat (2) @(negedge sys_clk);

        // Stop during the second dwell cycle
        v = vecs[0];
        pulse_start(v);
        @(negedge sys_clk);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        chk("stop.wave", 64'(wave_select), 64'h0);
        chk("stop.busy", 64'(busy), 64'h0);
        chk("stop.freq", 64'(freq_word), 64'h0);
        saw_done = done;
        repeat (12) begin
            @(negedge sys_clk);
            saw_done = saw_done | done | busy;
        end
        chk("stop.no_done", 64'(saw_done), 64'h0);

        // start and stop together in IDLE
        mode_en = 4'b0001; dwell = 24'd2; n_steps = 8'd0;
        start = 1'b1; stop = 1'b1;
        @(negedge sys_clk);
        start = 1'b0; stop = 1'b0;
        chk_idle_outs("startstop");
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            saw_done = saw_done | done | busy;
        end
        chk("startstop.quiet", 64'(saw_done), 64'h0);
`else
        // Loop mode: 0001 -> 0100 -> 0001 again with phase_clr, never done
        v = '{4'b0101, 32'd9, 32'd1, 8'd0, 24'd2, 0, 0, 0, 32'd0, 4'b0000};
        pulse_start(v);
        saw_done = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) chk("loop.second_wave", 64'(wave_select), 64'h4);
            if (k == 5) begin
                chk("loop.wrap_wave", 64'(wave_select), 64'h1);
                chk("loop.wrap_pclr", 64'(phase_clr), 64'h1);
                chk("loop.wrap_freq", 64'(freq_word), 64'd9);
            end
            saw_done = saw_done | done | ~busy;
            @(negedge sys_clk);
        end
        chk("loop.no_done", 64'(saw_done), 64'h0);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        chk("loop.stop_busy", 64'(busy), 64'h0);
        chk("loop.stop_wave", 64'(wave_select), 64'h0);
`endif

        // Asynchronous reset mid-sweep
        v = vecs[5];
        pulse_start(v);
        repeat (2) @(negedge sys_clk);
        chk("rst.busy_before", 64'(busy), 64'h1);
        sys_rst = 1'b1;
        #1;
        chk_idle_outs("rst.async");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge sys_clk);
            saw_done = saw_done | done | busy;
        end
        chk("rst.quiet", 64'(saw_done), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer that drives the `dds` block's `wave_select` and frequency tuning word through a programmed sweep. For each enabled waveform it steps the tuning word from a start value by a fixed increment, holding each point for a programmable dwell time. It sits between the control/register front end and the `dds` core and replaces manual `wave_select` driving. It pulses a phase-clear on every waveform change.

## Interface
- `FREQ_W`, 32: tuning-word width.
- `DWELL_W`, 24: dwell counter width.
- `STEP_W`, 8: step-count width.
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a sweep when idle.
- `stop`  in  1  one-cycle pulse; aborts the sweep.
- `mode_en`  in  4  waveform enable mask, bit i = one-hot `wave_select` code `1<<i`.
- `f_start`  in  FREQ_W  first tuning word of each waveform.
- `f_step`  in  FREQ_W  increment per step.
- `n_steps`  in  STEP_W  number of increments per waveform (points = n_steps+1).
- `dwell`  in  DWELL_W  cycles per point; 0 treated as 1.
- `wave_select`  out  4  one-hot waveform to `dds`; 0 = off.
- `freq_word`  out  FREQ_W  tuning word to `dds`.
- `phase_clr`  out  1  one-cycle pulse with every new waveform.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, DWELL, STEP, DONE.
- `start`, `mode_en`, `f_start`, `f_step`, `n_steps` and `dwell` are latched on an accepted `start`. Later input changes do not affect the running sweep.
- IDLE + `start` + `mode_en`≠0 -> DWELL:
  - wave = lowest set bit of `mode_en`.
  - `freq_word` = `f_start`.
  - step_idx = 0.
  - dwell counter loaded.
  - `phase_clr` pulses.
- DWELL: counts down. At expiry:
  - if step_idx < n_steps -> STEP.
  - else, if a higher enabled wave exists -> that wave, `freq_word` = `f_start`, step_idx = 0, `phase_clr` pulses, stay in DWELL.
  - else -> DONE.
- STEP: `freq_word` += `f_step`, modulo 2^FREQ_W (wrap allowed). step_idx++. -> DWELL. The STEP cycle counts as the first cycle of the new point's dwell.
- DONE: `done` pulses, `wave_select`=0, `freq_word`=0, `busy`=0 -> IDLE.
- `stop` in any non-IDLE state -> IDLE next cycle:
  - `wave_select`=0, `freq_word`=0, `busy`=0.
  - no `done` pulse.
- `start` while busy: ignored.
- `start` and `stop` in the same cycle: `stop` wins.
- `start` with `mode_en`=0: `done` pulses next cycle; `busy` stays 0; no `phase_clr`.

## Timing
- Reset values: `wave_select`=0, `freq_word`=0, `phase_clr`=0, `busy`=0, `done`=0, state IDLE.
- All outputs are registered.
- `start` sampled at cycle T -> `wave_select`, `freq_word`, `busy` and `phase_clr` are valid at T+1.
- Each point is held exactly D = max(`dwell`,1) cycles.
- One waveform occupies (n_steps+1)·D cycles. Waves are back-to-back with no gap.
- `done` asserts on the cycle after the last point's final dwell cycle. `busy` falls and `wave_select` goes to 0 in that same cycle.
- Reset asserted mid-sweep: all outputs return to their reset values immediately (asynchronous). No `done`.

## Configuration
- `DDS_SWEEP_LOOP_EN` defined: after the last enabled wave the sweep restarts at the lowest enabled wave, with `phase_clr` and `freq_word`=`f_start`. It never enters DONE; only `stop` or reset ends it, and `done` never pulses.
- Not defined: one-shot sweep as described above.

## Structure
- Package `dds_pkg`:
  - state enum.
  - one-hot wave constants WAVE_SINE/SQUARE/TRI/SAW = 4'b0001/0010/0100/1000, WAVE_OFF = 0.
  - default widths.
- Sub-module `dds_next_wave`: combinational. Given the latched mask and the current one-hot wave, it returns the next higher enabled wave and a `none` flag. It is also used for first-wave selection with current = 0.

## Test plan
- Reset then idle -> all outputs 0. Assert `sys_rst` mid-sweep -> outputs 0 within the same cycle.
- `mode_en`=4'b0001, `f_start`=100, `f_step`=10, `n_steps`=2, `dwell`=3, pulse `start` -> `freq_word` is 100, 110, 120, each held 3 cycles. `phase_clr` pulses once. `done` fires 10 cycles after `start`.
- `mode_en`=4'b1010, `n_steps`=0, `dwell`=2 -> `wave_select` 0010 for 2 cycles, then 1000 for 2 cycles, with a `phase_clr` at each change, then `done`.
- `f_start`=32'hFFFF_FFF0, `f_step`=32'h20, `n_steps`=1 -> second point is 32'h10 (wrap).
- `stop` pulsed in the 2nd dwell cycle -> next cycle `wave_select`=0, `busy`=0, no `done`. Same-cycle `start`+`stop` in IDLE -> remains IDLE.
- `dwell`=0 -> each point held 1 cycle. `mode_en`=0 plus `start` -> `done` at T+1 with `busy` never high. With `DDS_SWEEP_LOOP_EN`: wraps to the first wave, with `phase_clr` and no `done`.
